// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb: N-master to 1-slave AXI read-channel arbiter (round-robin AR, per-master outstanding limit).
// Optional build macro EASYAXI_RD_ARB_AR_SLICE_EN registers the slave AR channel in a one-entry slice.
module easyaxi_rd_arb #(
    parameter int NUM_MST  = 2,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_OUTS = 4,
    parameter int MIDX_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
    parameter int SID_W    = ID_W + MIDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MST-1:0]        mst_arvalid,
    output logic [NUM_MST-1:0]        mst_arready,
    input  logic [NUM_MST*ID_W-1:0]   mst_arid,
    input  logic [NUM_MST*ADDR_W-1:0] mst_araddr,
    input  logic [NUM_MST*8-1:0]      mst_arlen,
    input  logic [NUM_MST*3-1:0]      mst_arsize,
    input  logic [NUM_MST*2-1:0]      mst_arburst,
    output logic [NUM_MST-1:0]        mst_rvalid,
    input  logic [NUM_MST-1:0]        mst_rready,
    output logic [ID_W-1:0]           mst_rid,
    output logic [DATA_W-1:0]         mst_rdata,
    output logic [1:0]                mst_rresp,
    output logic                      mst_rlast,
    output logic                      slv_arvalid,
    input  logic                      slv_arready,
    output logic [SID_W-1:0]          slv_arid,
    output logic [ADDR_W-1:0]         slv_araddr,
    output logic [7:0]                slv_arlen,
    output logic [2:0]                slv_arsize,
    output logic [1:0]                slv_arburst,
    input  logic                      slv_rvalid,
    output logic                      slv_rready,
    input  logic [SID_W-1:0]          slv_rid,
    input  logic [DATA_W-1:0]         slv_rdata,
    input  logic [1:0]                slv_rresp,
    input  logic                      slv_rlast,
    output logic                      route_err,
    output logic                      dbg_state
);
    localparam int CNT_W = $clog2(MAX_OUTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTS);

    // Valid/ready: a transfer happens on a cycle where both valid and ready are high;
    // once valid is raised its payload is held until that transfer.
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t             state_q;
    logic [MIDX_W-1:0]  rr_q, rr_d, grant_q;
    logic [CNT_W-1:0]   cnt_q [NUM_MST];
    logic               route_err_q;

    logic [NUM_MST-1:0]   elig, ar_inc, r_dec, r_hit;
    logic [2*NUM_MST-1:0] rot;
    logic                 found, hs_vld, r_in_range;
    logic [MIDX_W-1:0]    win, src_idx, hs_idx, r_idx;
    logic [ID_W-1:0]      sel_id;
    logic [ADDR_W-1:0]    sel_addr;
    logic [7:0]           sel_len;
    logic [2:0]           sel_size;
    logic [1:0]           sel_burst;
    int                   sum, nxt;

    // Round-robin: rotate the eligible vector so the pointer lands at bit 0, take the first set bit.
    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            elig[i] = mst_arvalid[i] && (cnt_q[i] < CNT_MAX);
        end
        rot   = {elig, elig} >> rr_q;
        found = 1'b0;
        win   = '0;
        sum   = 0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = int'(rr_q) + k;
                if (sum >= NUM_MST) sum = sum - NUM_MST;
                win   = MIDX_W'(sum);
            end
        end
    end

`ifdef EASYAXI_RD_ARB_AR_SLICE_EN
    logic [ID_W-1:0]   sl_id_q;
    logic [ADDR_W-1:0] sl_addr_q;
    logic [7:0]        sl_len_q;
    logic [2:0]        sl_size_q;
    logic [1:0]        sl_burst_q;

    assign src_idx     = win;
    assign hs_vld      = found && !rst && ((state_q != LOCK) || slv_arready);
    assign hs_idx      = win;
    assign slv_arvalid = (state_q == LOCK);
    assign slv_arid    = {grant_q, sl_id_q};
    assign slv_araddr  = sl_addr_q;
    assign slv_arlen   = sl_len_q;
    assign slv_arsize  = sl_size_q;
    assign slv_arburst = sl_burst_q;
`else
    assign src_idx     = (state_q == LOCK) ? grant_q : win;
    assign slv_arvalid = ((state_q == LOCK) || found) && !rst;
    assign hs_vld      = slv_arvalid && slv_arready;
    assign hs_idx      = src_idx;
    assign slv_arid    = {src_idx, sel_id};
    assign slv_araddr  = sel_addr;
    assign slv_arlen   = sel_len;
    assign slv_arsize  = sel_size;
    assign slv_arburst = sel_burst;
`endif

    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (src_idx == MIDX_W'(i)) begin
                sel_id    = mst_arid[i*ID_W +: ID_W];
                sel_addr  = mst_araddr[i*ADDR_W +: ADDR_W];
                sel_len   = mst_arlen[i*8 +: 8];
                sel_size  = mst_arsize[i*3 +: 3];
                sel_burst = mst_arburst[i*2 +: 2];
            end
        end
    end

    // R routing: the upper slave-ID bits name the master; unknown indices are sunk.
    assign r_idx = slv_rid[SID_W-1:ID_W];

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            r_hit[i] = (r_idx == MIDX_W'(i));
        end
        r_in_range = |r_hit;
        slv_rready = !r_in_range;
        for (int i = 0; i < NUM_MST; i++) begin
            if (r_hit[i]) slv_rready = mst_rready[i];
        end
        if (rst) slv_rready = 1'b0;
        mst_rvalid = r_hit & {NUM_MST{slv_rvalid && !rst}};
        for (int i = 0; i < NUM_MST; i++) begin
            mst_arready[i] = hs_vld && (hs_idx == MIDX_W'(i));
            ar_inc[i]      = mst_arready[i];
            r_dec[i]       = r_hit[i] && slv_rvalid && slv_rready && slv_rlast && (cnt_q[i] != '0);
        end
        rr_d = rr_q;
        nxt  = 0;
        if (hs_vld) begin
            nxt = int'(hs_idx) + 1;
            if (nxt >= NUM_MST) nxt = 0;
            rr_d = MIDX_W'(nxt);
        end
    end

    assign mst_rid   = slv_rid[ID_W-1:0];
    assign mst_rdata = slv_rdata;
    assign mst_rresp = slv_rresp;
    assign mst_rlast = slv_rlast;
    assign route_err = route_err_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            route_err_q <= 1'b0;
            for (int i = 0; i < NUM_MST; i++) cnt_q[i] <= '0;
`ifdef EASYAXI_RD_ARB_AR_SLICE_EN
            sl_id_q    <= '0;
            sl_addr_q  <= '0;
            sl_len_q   <= '0;
            sl_size_q  <= '0;
            sl_burst_q <= '0;
`endif
        end else begin
            rr_q        <= rr_d;
            route_err_q <= slv_rvalid && !r_in_range;
            for (int i = 0; i < NUM_MST; i++) begin
                if (ar_inc[i] && !r_dec[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (!ar_inc[i] && r_dec[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
`ifdef EASYAXI_RD_ARB_AR_SLICE_EN
            // LOCK here means the slice holds a request not yet taken by the slave.
            if (hs_vld) begin
                state_q    <= LOCK;
                grant_q    <= win;
                sl_id_q    <= sel_id;
                sl_addr_q  <= sel_addr;
                sl_len_q   <= sel_len;
                sl_size_q  <= sel_size;
                sl_burst_q <= sel_burst;
            end else if (slv_arready) begin
                state_q <= IDLE;
            end
`else
            case (state_q)
                IDLE: if (found && !slv_arready) begin
                    state_q <= LOCK;
                    grant_q <= win;
                end
                LOCK: if (slv_arready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Directed self-checking bench for easyaxi_rd_arb (3 masters, MAX_OUTS=2, combinational AR path).
module tb_easyaxi_rd_arb;
    localparam int NM = 3;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;
    localparam int SW = 6;

    logic clk, rst;
    logic [NM-1:0] mst_arvalid, mst_arready, mst_rvalid, mst_rready;
    logic [NM*IW-1:0] mst_arid;
    logic [NM*AW-1:0] mst_araddr;
    logic [NM*8-1:0] mst_arlen;
    logic [NM*3-1:0] mst_arsize;
    logic [NM*2-1:0] mst_arburst;
    logic [IW-1:0] mst_rid;
    logic [DW-1:0] mst_rdata;
    logic [1:0] mst_rresp;
    logic mst_rlast;
    logic slv_arvalid, slv_arready;
    logic [SW-1:0] slv_arid;
    logic [AW-1:0] slv_araddr;
    logic [7:0] slv_arlen;
    logic [2:0] slv_arsize;
    logic [1:0] slv_arburst;
    logic slv_rvalid, slv_rready;
    logic [SW-1:0] slv_rid;
    logic [DW-1:0] slv_rdata;
    logic [1:0] slv_rresp;
    logic slv_rlast, route_err, dbg_state;

    int checks = 0;
    int errors = 0;

    easyaxi_rd_arb #(.NUM_MST(NM), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTS(MO)) dut (
        .clk(clk), .rst(rst),
        .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_arid(mst_arid),
        .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
        .mst_arburst(mst_arburst), .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
        .mst_rid(mst_rid), .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
        .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_arid(slv_arid),
        .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
        .slv_arburst(slv_arburst), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
        .slv_rid(slv_rid), .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rlast(slv_rlast),
        .route_err(route_err), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mst_arvalid = '0; mst_arid = '0; mst_araddr = '0; mst_arlen = '0;
        mst_arsize = '0; mst_arburst = '0; mst_rready = '0;
        slv_arready = 1'b0; slv_rvalid = 1'b0; slv_rid = '0;
        slv_rdata = '0; slv_rresp = '0; slv_rlast = 1'b0;
    endtask

    task automatic set_ar(input int m, input logic v, input logic [IW-1:0] id,
                          input logic [AW-1:0] addr, input logic [7:0] len);
        mst_arvalid[m]        = v;
        mst_arid[m*IW +: IW]  = id;
        mst_araddr[m*AW +: AW] = addr;
        mst_arlen[m*8 +: 8]   = len;
        mst_arsize[m*3 +: 3]  = 3'd2;
        mst_arburst[m*2 +: 2] = 2'd1;
    endtask

    task automatic set_r(input logic v, input logic [SW-1:0] rid,
                         input logic [DW-1:0] data, input logic last);
        slv_rvalid = v; slv_rid = rid; slv_rdata = data; slv_rlast = last;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mst_arvalid = 3'b001; slv_arready = 1'b1; mst_rready = 3'b111;
        set_r(1'b1, 6'h30, 32'h0, 1'b1);
        step();
        step();
        checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL rst_arready got %b exp 000", mst_arready); end
        checks++; if (slv_arvalid !== 1'b0) begin errors++; $display("FAIL rst_slv_arvalid got %b exp 0", slv_arvalid); end
        checks++; if (slv_rready !== 1'b0) begin errors++; $display("FAIL rst_slv_rready got %b exp 0", slv_rready); end
        checks++; if (mst_rvalid !== 3'b000) begin errors++; $display("FAIL rst_mst_rvalid got %b exp 000", mst_rvalid); end
        checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL rst_route_err got %b exp 0", route_err); end
        checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rst_state got %b exp 0", dbg_state); end
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_ar(0, 1'b1, 4'h3, 32'h1000, 8'd3);
        slv_arready = 1'b1;
        #1;
        checks++; if (slv_arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid got %b exp 1", slv_arvalid); end
        checks++; if (slv_arid !== 6'h03) begin errors++; $display("FAIL single_arid got %h exp 03", slv_arid); end
        checks++; if (slv_araddr !== 32'h1000) begin errors++; $display("FAIL single_araddr got %h exp 1000", slv_araddr); end
        checks++; if (slv_arlen !== 8'd3) begin errors++; $display("FAIL single_arlen got %0d exp 3", slv_arlen); end
        checks++; if (mst_arready !== 3'b001) begin errors++; $display("FAIL single_arready got %b exp 001", mst_arready); end
        step();
        set_ar(0, 1'b0, 4'h0, 32'h0, 8'd0);
        slv_arready = 1'b0;
        mst_rready  = 3'b001;
        for (int b = 0; b < 4; b++) begin
            set_r(1'b1, 6'h03, 32'hA0 + b, (b == 3));
            #1;
            checks++; if (mst_rvalid !== 3'b001) begin errors++; $display("FAIL single_rvalid beat %0d got %b exp 001", b, mst_rvalid); end
            checks++; if (mst_rid !== 4'h3) begin errors++; $display("FAIL single_rid beat %0d got %h exp 3", b, mst_rid); end
            checks++; if (mst_rdata !== 32'hA0 + b) begin errors++; $display("FAIL single_rdata beat %0d got %h exp %h", b, mst_rdata, 32'hA0 + b); end
            checks++; if (mst_rlast !== (b == 3)) begin errors++; $display("FAIL single_rlast beat %0d got %b", b, mst_rlast); end
            checks++; if (slv_rready !== 1'b1) begin errors++; $display("FAIL single_rready beat %0d got %b exp 1", b, slv_rready); end
            step();
        end
        set_r(1'b1, 6'h03, 32'hBB, 1'b0);
        mst_rready = 3'b000;
        #1;
        checks++; if (slv_rready !== 1'b0) begin errors++; $display("FAIL single_backpressure got %b exp 0", slv_rready); end
        step();
        set_r(1'b0, 6'h0, 32'h0, 1'b0);
        // counter back at 0 after rlast: two more ARs fit, the third stalls
        set_ar(0, 1'b1, 4'h3, 32'h2000, 8'd0);
        slv_arready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (mst_arready !== ((n < 2) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL single_cnt_free ar %0d got %b", n, mst_arready); end
            step();
        end
        apply_reset();
    endtask

    task automatic test_alternate();
        logic [1:0] ei;
        logic [SW-1:0] eid;
        apply_reset();
        set_ar(0, 1'b1, 4'h1, 32'h100, 8'd0);
        set_ar(1, 1'b1, 4'h2, 32'h200, 8'd0);
        slv_arready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            ei  = 2'(g % 2);
            eid = {ei, (ei == 2'd0) ? 4'h1 : 4'h2};
            #1;
            checks++; if (slv_arid !== eid) begin errors++; $display("FAIL alt_arid grant %0d got %h exp %h", g, slv_arid, eid); end
            checks++; if (mst_arready !== (3'b001 << ei)) begin errors++; $display("FAIL alt_arready grant %0d got %b exp %b", g, mst_arready, 3'b001 << ei); end
            step();
        end
        #1;
        checks++; if (slv_arvalid !== 1'b0) begin errors++; $display("FAIL alt_full_arvalid got %b exp 0", slv_arvalid); end
        checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL alt_full_arready got %b exp 000", mst_arready); end
        apply_reset();
    endtask

    task automatic test_lock();
        apply_reset();
        set_ar(0, 1'b1, 4'h4, 32'h400, 8'd1);
        slv_arready = 1'b1;
        #1;
        checks++; if (mst_arready !== 3'b001) begin errors++; $display("FAIL lock_pre_arready got %b exp 001", mst_arready); end
        step();
        set_ar(0, 1'b1, 4'h5, 32'h500, 8'd1);
        slv_arready = 1'b0;
        #1;
        checks++; if (slv_arid !== 6'h05) begin errors++; $display("FAIL lock_idle_arid got %h exp 05", slv_arid); end
        checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL lock_idle_arready got %b exp 000", mst_arready); end
        step();
        set_ar(1, 1'b1, 4'h6, 32'h600, 8'd2);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (slv_arid !== 6'h05) begin errors++; $display("FAIL lock_hold_arid cyc %0d got %h exp 05", c, slv_arid); end
            checks++; if (slv_araddr !== 32'h500) begin errors++; $display("FAIL lock_hold_addr cyc %0d got %h exp 500", c, slv_araddr); end
            checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL lock_state cyc %0d got %b exp 1", c, dbg_state); end
            checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL lock_hold_arready cyc %0d got %b exp 000", c, mst_arready); end
            step();
        end
        slv_arready = 1'b1;
        #1;
        checks++; if (mst_arready !== 3'b001) begin errors++; $display("FAIL lock_release_arready got %b exp 001", mst_arready); end
        step();
        set_ar(0, 1'b0, 4'h0, 32'h0, 8'd0);
        #1;
        checks++; if (slv_arid !== 6'h16) begin errors++; $display("FAIL lock_next_arid got %h exp 16", slv_arid); end
        checks++; if (mst_arready !== 3'b010) begin errors++; $display("FAIL lock_next_arready got %b exp 010", mst_arready); end
        checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL lock_next_state got %b exp 0", dbg_state); end
        apply_reset();
    endtask

    task automatic test_max_outs();
        apply_reset();
        set_ar(0, 1'b1, 4'h7, 32'h700, 8'd0);
        slv_arready = 1'b1;
        mst_rready  = 3'b001;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++; if (mst_arready !== 3'b001) begin errors++; $display("FAIL max_accept %0d got %b exp 001", n, mst_arready); end
            step();
        end
        #1;
        checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL max_stall_arready got %b exp 000", mst_arready); end
        checks++; if (slv_arvalid !== 1'b0) begin errors++; $display("FAIL max_stall_arvalid got %b exp 0", slv_arvalid); end
        step();
        set_r(1'b1, 6'h07, 32'h11, 1'b0);
        step();
        set_r(1'b0, 6'h07, 32'h0, 1'b0);
        #1;
        checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL max_nonlast got %b exp 000", mst_arready); end
        step();
        set_r(1'b1, 6'h07, 32'h22, 1'b1);
        #1;
        checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL max_rlast_cycle got %b exp 000", mst_arready); end
        step();
        // one slot free: AR and rlast in the same cycle keep the count at 1
        #1;
        checks++; if (mst_arready !== 3'b001) begin errors++; $display("FAIL max_inc_dec got %b exp 001", mst_arready); end
        step();
        set_r(1'b0, 6'h07, 32'h0, 1'b0);
        #1;
        checks++; if (mst_arready !== 3'b001) begin errors++; $display("FAIL max_after_incdec got %b exp 001", mst_arready); end
        step();
        #1;
        checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL max_refull got %b exp 000", mst_arready); end
        apply_reset();
    endtask

    task automatic test_route_err();
        apply_reset();
        set_r(1'b1, 6'h30, 32'hDEAD, 1'b1);
        slv_rresp  = 2'b10;
        mst_rready = 3'b111;
        #1;
        checks++; if (mst_rvalid !== 3'b000) begin errors++; $display("FAIL route_rvalid got %b exp 000", mst_rvalid); end
        checks++; if (slv_rready !== 1'b1) begin errors++; $display("FAIL route_sink got %b exp 1", slv_rready); end
        checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL route_err_early got %b exp 0", route_err); end
        checks++; if (mst_rresp !== 2'b10) begin errors++; $display("FAIL route_rresp got %b exp 10", mst_rresp); end
        step();
        set_r(1'b0, 6'h0, 32'h0, 1'b0);
        checks++; if (route_err !== 1'b1) begin errors++; $display("FAIL route_err_pulse got %b exp 1", route_err); end
        step();
        checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL route_err_clear got %b exp 0", route_err); end
        set_r(1'b1, 6'h29, 32'h55, 1'b1);
        mst_rready = 3'b011;
        #1;
        checks++; if (mst_rvalid !== 3'b100) begin errors++; $display("FAIL route_m2_rvalid got %b exp 100", mst_rvalid); end
        checks++; if (slv_rready !== 1'b0) begin errors++; $display("FAIL route_m2_rready got %b exp 0", slv_rready); end
        checks++; if (mst_rid !== 4'h9) begin errors++; $display("FAIL route_m2_rid got %h exp 9", mst_rid); end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_ar(0, 1'b1, 4'h1, 32'h800, 8'd3);
        slv_arready = 1'b1;
        step();
        step();
        slv_arready = 1'b0;
        set_ar(1, 1'b1, 4'h2, 32'h900, 8'd0);
        set_r(1'b1, 6'h01, 32'h77, 1'b0);
        mst_rready = 3'b001;
        step();
        #1;
        checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL mid_pre_state got %b exp 1", dbg_state); end
        rst = 1'b1;
        #1;
        checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL mid_state got %b exp 0", dbg_state); end
        checks++; if (slv_arvalid !== 1'b0) begin errors++; $display("FAIL mid_arvalid got %b exp 0", slv_arvalid); end
        checks++; if (mst_rvalid !== 3'b000) begin errors++; $display("FAIL mid_rvalid got %b exp 000", mst_rvalid); end
        checks++; if (slv_rready !== 1'b0) begin errors++; $display("FAIL mid_rready got %b exp 0", slv_rready); end
        checks++; if (mst_arready !== 3'b000) begin errors++; $display("FAIL mid_arready got %b exp 000", mst_arready); end
        clear_inputs();
        step();
        rst = 1'b0;
        set_ar(0, 1'b1, 4'h3, 32'hA00, 8'd0);
        set_ar(1, 1'b1, 4'h4, 32'hB00, 8'd0);
        slv_arready = 1'b1;
        #1;
        checks++; if (mst_arready !== 3'b001) begin errors++; $display("FAIL mid_fresh0 got %b exp 001", mst_arready); end
        checks++; if (slv_arid !== 6'h03) begin errors++; $display("FAIL mid_fresh_arid got %h exp 03", slv_arid); end
        step();
        #1;
        checks++; if (mst_arready !== 3'b010) begin errors++; $display("FAIL mid_fresh1 got %b exp 010", mst_arready); end
        step();
        #1;
        checks++; if (mst_arready !== 3'b001) begin errors++; $display("FAIL mid_fresh2 got %b exp 001", mst_arready); end
        step();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_max_outs();
        test_route_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
